// File: rtl/dsa_pkg.sv
// Shared types and defaults for the memory arbiter slice.
package dsa_pkg;

  localparam int unsigned DSA_DATA_WIDTH = 8;
  localparam int unsigned DSA_ADDR_WIDTH = 16;

  // State encoding doubles as the owner encoding.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_e;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_M0   = 2'b01;
  localparam logic [1:0] OWNER_M1   = 2'b10;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-tag delay line: tracks which master issued each read so the RAM data
// returning RD_LAT cycles later can be steered back to it.
module rd_tag_pipe #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_id,
  output logic out_valid,
  output logic out_id
);

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] id_q;

  // Shift {valid, master_id} one stage per cycle; reset drops in-flight reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q[0] <= in_valid;
      id_q[0]  <= in_id;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[RD_LAT-1];
  assign out_id    = id_q[RD_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port-per-direction RAM.
// m0 = JTAG/debug, m1 = interpolation engine. Ownership is held per burst.
// Optional feature: define MEM_ARB_PERF_EN to build the grant/wait counters;
// otherwise the perf_* ports are tied to zero.
module mem_arbiter
  import dsa_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DSA_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DSA_ADDR_WIDTH,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req_valid,
  input  logic                  m0_req_we,
  input  logic [ADDR_WIDTH-1:0] m0_req_addr,
  input  logic [DATA_WIDTH-1:0] m0_req_wdata,
  input  logic                  m0_req_last,
  output logic                  m0_req_ready,
  output logic                  m0_rsp_valid,
  output logic [DATA_WIDTH-1:0] m0_rsp_rdata,
  input  logic                  m1_req_valid,
  input  logic                  m1_req_we,
  input  logic [ADDR_WIDTH-1:0] m1_req_addr,
  input  logic [DATA_WIDTH-1:0] m1_req_wdata,
  input  logic                  m1_req_last,
  output logic                  m1_req_ready,
  output logic                  m1_rsp_valid,
  output logic [DATA_WIDTH-1:0] m1_rsp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_wraddress,
  output logic [ADDR_WIDTH-1:0] ram_rdaddress,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [1:0]            owner,
  output logic [15:0]           perf_grant0,
  output logic [15:0]           perf_grant1,
  output logic [15:0]           perf_wait
);

  // Wide enough to hold MAX_BURST itself so the counter never wraps.
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  arb_state_e state_q, state_d;
  logic       rr_q, rr_d;  // 0 = m0 wins next contention, 1 = m1
  logic [CntW-1:0] beat_cnt_q;

  logic                  sel;
  logic                  own_valid;
  logic                  own_we;
  logic                  own_last;
  logic [ADDR_WIDTH-1:0] own_addr;
  logic [DATA_WIDTH-1:0] own_wdata;
  logic                  other_valid;
  logic                  accept;
  logic                  burst_full;
  logic                  enter;
  logic                  rsp_valid;
  logic                  rsp_id;

  assign m0_req_ready = (state_q == OWN0);
  assign m1_req_ready = (state_q == OWN1);
  assign owner        = state_q;

  // Owner request mux and RAM drive; writes only fire on an accepted beat.
  always_comb begin
    sel         = (state_q == OWN1);
    own_valid   = sel ? m1_req_valid : m0_req_valid;
    own_we      = sel ? m1_req_we    : m0_req_we;
    own_last    = sel ? m1_req_last  : m0_req_last;
    own_addr    = sel ? m1_req_addr  : m0_req_addr;
    own_wdata   = sel ? m1_req_wdata : m0_req_wdata;
    other_valid = sel ? m0_req_valid : m1_req_valid;
    accept      = (state_q != IDLE) & own_valid;
    burst_full  = (beat_cnt_q == CntW'(MAX_BURST - 1));

    ram_wraddress = own_addr;
    ram_rdaddress = own_addr;
    ram_data      = own_wdata;
    ram_wren      = accept & own_we;
  end

  // Next-state: grant from IDLE, release on last / full burst / owner drop.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (m0_req_valid && m1_req_valid) begin
          state_d = rr_q ? OWN1 : OWN0;
        end else if (m0_req_valid) begin
          state_d = OWN0;
        end else if (m1_req_valid) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (!own_valid || (accept && (own_last || burst_full))) begin
          rr_d = ~sel;
          if (other_valid) begin
            state_d = sel ? OWN0 : OWN1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    enter = (state_d != IDLE) && (state_d != state_q);
  end

  // State, round-robin pointer and per-grant beat counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      if (enter) begin
        beat_cnt_q <= '0;
      end else if (accept && (beat_cnt_q != CntW'(MAX_BURST))) begin
        beat_cnt_q <= beat_cnt_q + CntW'(1);
      end
    end
  end

  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (accept & ~own_we),
    .in_id     (sel),
    .out_valid (rsp_valid),
    .out_id    (rsp_id)
  );

  assign m0_rsp_valid = rsp_valid & ~rsp_id;
  assign m1_rsp_valid = rsp_valid & rsp_id;
  assign m0_rsp_rdata = ram_q;
  assign m1_rsp_rdata = ram_q;

`ifdef MEM_ARB_PERF_EN
  logic [15:0] grant0_q, grant1_q, wait_q;
  logic        waiting;

  assign waiting = (m0_req_valid & ~m0_req_ready) | (m1_req_valid & ~m1_req_ready);

  // Saturating grant and wait counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant0_q <= '0;
      grant1_q <= '0;
      wait_q   <= '0;
    end else begin
      if (enter && (state_d == OWN0) && (grant0_q != 16'hFFFF)) grant0_q <= grant0_q + 16'd1;
      if (enter && (state_d == OWN1) && (grant1_q != 16'hFFFF)) grant1_q <= grant1_q + 16'd1;
      if (waiting && (wait_q != 16'hFFFF)) wait_q <= wait_q + 16'd1;
    end
  end

  assign perf_grant0 = grant0_q;
  assign perf_grant1 = grant1_q;
  assign perf_wait   = wait_q;
`else
  assign perf_grant0 = '0;
  assign perf_grant1 = '0;
  assign perf_wait   = '0;
`endif

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, RAM data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, RAM address width.
REQ-003 SHALL have parameter RD_LAT, default 1, RAM read latency in cycles (1..4).
REQ-004 SHALL have parameter MAX_BURST, default 16, maximum beats per grant (2..256).
REQ-005 SHALL use one clock and a synchronous, active-high reset; all ports are listed below.
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- mN_req_valid  in  1  request valid, N in {0,1}; m0 = JTAG/debug, m1 = interpolation engine
- mN_req_we  in  1  1 = write, 0 = read
- mN_req_addr  in  ADDR_WIDTH  beat address
- mN_req_wdata  in  DATA_WIDTH  write data
- mN_req_last  in  1  final beat of the burst
- mN_req_ready  out  1  beat accepted when valid & ready
- mN_rsp_valid  out  1  read data valid
- mN_rsp_rdata  out  DATA_WIDTH  read data
- ram_wraddress  out  ADDR_WIDTH  RAM write address
- ram_rdaddress  out  ADDR_WIDTH  RAM read address
- ram_data  out  DATA_WIDTH  RAM write data
- ram_wren  out  1  RAM write enable
- ram_q  in  DATA_WIDTH  RAM read data
- owner  out  2  00 none, 01 m0, 10 m1
- perf_grant0, perf_grant1, perf_wait  out  16 each  performance counters

Function
REQ-006 SHALL implement FSM states IDLE, OWN0 and OWN1; mN_req_ready = (state == OWNn), combinational from state.
REQ-007 IDLE: if exactly one master is valid, SHALL go to OWN of that master next cycle; if both are valid, SHALL go to OWN of rr_ptr's master; if neither is valid, SHALL stay in IDLE.
REQ-008 On each accepted beat, SHALL drive ram_wraddress = ram_rdaddress = owner addr, ram_data = owner wdata, and ram_wren = we, all combinationally; ram_wren SHALL be 0 on every non-accept cycle.
REQ-009 OWNn SHALL end after a beat accepted with last = 1, after beat count reaches MAX_BURST, or on a cycle where the owner has valid = 0.
REQ-010 On exit from OWNn, rr_ptr SHALL point to the other master; the next state SHALL be OWN of the other master if it is valid that cycle, else IDLE.
REQ-011 The beat counter SHALL clear on entry to OWNn and SHALL increment per accepted beat; it SHALL NOT wrap.
REQ-012 Each accepted read SHALL produce mN_rsp_valid for the issuing master exactly RD_LAT cycles later, with rsp_rdata = ram_q in that cycle.
REQ-013 In-flight read responses SHALL be delivered even if ownership changes; back-to-back reads SHALL return one response per cycle, in order.
REQ-014 mN_rsp_rdata SHALL equal ram_q when rsp_valid = 0; rsp_valid SHALL be 0 for writes.
REQ-015 SHALL perform no read-after-write forwarding; same-address hazards follow RAM behaviour.
REQ-016 Peak throughput SHALL be one beat per cycle; grant latency from IDLE SHALL be 1 cycle; handoff between masters SHALL take 0 idle cycles.

Reset
REQ-017 Reset SHALL force: state IDLE, rr_ptr = m0, beat count 0, all ready/rsp_valid/ram_wren 0, owner 00, perf counters 0.
REQ-018 Reset mid-burst or with reads in flight SHALL discard those responses; no rsp_valid SHALL appear after reset deasserts.

Configuration
REQ-019 With MEM_ARB_PERF_EN defined:
- perf_grant0/1 SHALL count grants to each master.
- perf_wait SHALL count cycles where any master has valid & !ready.
- All three counters SHALL saturate at 16'hFFFF.
REQ-020 Without MEM_ARB_PERF_EN, the perf_* ports SHALL exist and be constant 0, and no counter logic SHALL be synthesized.

Structure
REQ-021 Shared package dsa_pkg SHALL hold the arb_state_e enum (IDLE, OWN0, OWN1), the owner encoding constants, and DATA_WIDTH/ADDR_WIDTH defaults.
REQ-022 SHALL contain one sub-module, rd_tag_pipe: an RD_LAT-deep shift register of {valid, master_id}, reset to 0.

Verification
REQ-023 m0 only: write 0xA5 @0x0010 (last = 1), then read @0x0010 -> ram_wren one cycle with addr 0x0010; m0_rsp_valid RD_LAT cycles after read accept with rdata 0xA5.
REQ-024 Both valid from IDLE after reset -> m0 granted first; after m0 last, m1 owns the next cycle with no IDLE gap; the next contention goes to m0.
REQ-025 m1 burst of 20 reads with last never asserted and m0 waiting -> m1 gets exactly MAX_BURST = 16 beats, then m0 is granted.
REQ-026 m0 issues 4 back-to-back reads, then ownership passes to m1 -> 4 m0 responses in order; no m1_rsp_valid from them.
REQ-027 Reset asserted with 1 read in flight (RD_LAT = 2) -> no rsp_valid after reset; owner 00; ready 0.
REQ-028 MEM_ARB_PERF_EN, m1 held waiting 5 cycles -> perf_wait = 5; counters stay at 0xFFFF once saturated.
